vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receiving end of the VGA pixel interface driven by the bit generator.
- Samples vga_hsync, vga_vsync, blank_n and the 8-bit RGB buses each pixel clock, locks to the 640x480 timing, and recovers pixel coordinates.
- Computes a per-frame colour checksum and flags timing violations.
- Used in simulation and on-chip self-test to check the rendered frame without a monitor.

Parameters:
- CORDW, 16: coordinate output width (bits).
- H_TOTAL, 800: expected clocks between hsync falling edges.
- H_ACTIVE, 640: expected active pixels per line.
- V_ACTIVE, 480: expected active lines per frame.
- CHANW, 4: colour bits per channel used in the checksum (MSBs of each 8-bit channel).

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- reset  in  1  asynchronous, active-low reset.
- vga_hsync  in  1  horizontal sync, active-low pulse.
- vga_vsync  in  1  vertical sync, active-low pulse.
- blank_n  in  1  high during active video.
- vga_r  in  8  red channel.
- vga_g  in  8  green channel.
- vga_b  in  8  blue channel.
- px  out  CORDW  recovered x of the current active pixel.
- py  out  CORDW  recovered y of the current active line.
- pix_valid  out  1  px, py and pix_colr are valid this cycle.
- pix_colr  out  3*CHANW  {r[7:4], g[7:4], b[7:4]} of the current pixel.
- locked  out  1  decoder is locked to the timing.
- frame_done  out  1  one-cycle pulse; checksum and line_count are updated.
- checksum  out  16  colour checksum of the last complete frame.
- line_count  out  CORDW  active lines counted in the last frame.
- sync_err  out  1  one-cycle pulse on any timing violation.

Behaviour:
- Reset (asynchronous, reset=0):
  - All outputs are 0; state is SEARCH.
  - Internal counters and previous-sample registers are cleared; previous hsync, vsync and blank_n are cleared to their idle values (1, 1, 0).
  - Reset mid-frame discards the partial checksum, and the decoder must re-lock.
- Edge detection: each signal is compared against its previous-cycle sample. A falling hsync/vsync edge is prev=1, cur=0. A blank_n rise or fall is detected the same way.
- hcnt counts clocks since the last hsync falling edge (12 bits). On each hsync falling edge:
  - the period is taken as hcnt+1 and compared with H_TOTAL;
  - hcnt is then set to 0.
- State machine:
  - SEARCH: on an hsync fall with period==H_TOTAL, go to ALIGN; otherwise stay in SEARCH.
  - ALIGN: on an hsync fall with period!=H_TOTAL, return to SEARCH. On a vsync fall, go to LOCKED and clear py and the checksum accumulator.
  - LOCKED: locked=1. On an hsync fall with period!=H_TOTAL, go to SEARCH, drop locked the next cycle, and pulse sync_err.
- Pixel path (LOCKED only; latency 1 clock from the input sample):
  - While blank_n=1, the next cycle drives pix_valid=1, px=xcnt, py=ycnt and pix_colr from the channel MSBs.
  - xcnt increments per active pixel and clears on each blank_n rise.
  - On a blank_n fall, ycnt increments.
  - If the active pixel count on that line != H_ACTIVE, sync_err pulses; the decoder stays locked.
  - pix_valid=0 whenever blank_n=0 or not LOCKED.
- Checksum:
  - Each valid pixel adds the zero-extended 12-bit colour into a 16-bit accumulator, modulo 2^16 (wraps, no saturation).
- Frame end, on a vsync fall while LOCKED:
  - checksum <= accumulator, line_count <= ycnt, and frame_done pulses for 1 clock.
  - ycnt and the accumulator are cleared in the same cycle.
  - If ycnt != V_ACTIVE, sync_err pulses alongside frame_done.
  - The first vsync fall (the ALIGN->LOCKED transition) does not produce frame_done.
- Simultaneous events:
  - vsync fall coinciding with a pixel: that pixel is counted in the new frame.
  - hsync-period error coinciding with frame end: unlock takes priority, with no frame_done.
- Width rules:
  - xcnt, ycnt and line_count saturate at 2^CORDW-1.
  - hcnt saturates at 4095; a saturated hcnt is always a period mismatch.

Test Plan:
- Two full 800x525 frames of solid colour 0x137 (r=0x10, g=0x30, b=0x70) -> locked=1 after the first vsync fall; a single frame_done pulse with checksum=0xD000 and line_count=480; no sync_err.
- Gradient frame with colour = x[3:0] replicated into all three channels -> px runs 0..639 and py 0..479 on pix_valid; the first valid pixel px=0, py=0 appears 1 clock after the first blank_n rise.
- While locked, shorten one line to 799 clocks -> sync_err pulse, locked=0 next cycle; relock only after a correct line and a subsequent vsync fall.
- Frame with only 479 active lines -> frame_done with line_count=479 plus a simultaneous sync_err; locked stays 1.
- Assert reset=0 mid-frame (line 200) -> all outputs 0 immediately; after release, locked=0 until a valid line and a vsync fall, and the next checksum reflects only full frames.
- Line with 641 blank_n-high cycles -> sync_err at that line's blank_n fall; checksum still includes all 641 pixels.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sink: timing lock, pixel coordinate recovery, frame checksum
module vga_sync_decoder #(
    parameter int CORDW    = 16,
    parameter int H_TOTAL  = 800,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CHANW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vga_hsync,
    input  logic                 vga_vsync,
    input  logic                 blank_n,
    input  logic [7:0]           vga_r,
    input  logic [7:0]           vga_g,
    input  logic [7:0]           vga_b,
    output logic [CORDW-1:0]     px,
    output logic [CORDW-1:0]     py,
    output logic                 pix_valid,
    output logic [3*CHANW-1:0]   pix_colr,
    output logic                 locked,
    output logic                 frame_done,
    output logic [15:0]          checksum,
    output logic [CORDW-1:0]     line_count,
    output logic                 sync_err
);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_prev_hs;
    logic               r_prev_vs;
    logic               r_prev_bl;
    logic [11:0]        r_hcnt;
    logic [CORDW-1:0]   r_xcnt;
    logic [CORDW-1:0]   r_ycnt;
    logic [15:0]        r_acc;

    logic               w_hs_fall;
    logic               w_vs_fall;
    logic               w_bl_rise;
    logic               w_bl_fall;
    logic               w_period_ok;
    logic               w_hs_bad;
    logic               w_in_lock;
    logic               w_enter_lock;
    logic               w_frame_end;
    logic               w_line_err;
    logic               w_pix;
    logic [CORDW-1:0]   w_x;
    logic [CORDW-1:0]   w_x_inc;
    logic [3*CHANW-1:0] w_colr;
    logic [15:0]        w_colr_ext;
    logic               w_unused_lsbs;

    assign w_hs_fall   = r_prev_hs & ~vga_hsync;
    assign w_vs_fall   = r_prev_vs & ~vga_vsync;
    assign w_bl_rise   = ~r_prev_bl & blank_n;
    assign w_bl_fall   = r_prev_bl & ~blank_n;
    // A saturated hcnt can never match, whatever H_TOTAL is
    assign w_period_ok = (r_hcnt != 12'hFFF) && (({1'b0, r_hcnt} + 13'd1) == 13'(H_TOTAL));
    assign w_hs_bad    = w_hs_fall & ~w_period_ok;

    assign w_in_lock    = (r_state == LOCKED);
    assign w_enter_lock = (r_state == ALIGN) && !w_hs_bad && w_vs_fall;
    assign w_frame_end  = w_in_lock && w_vs_fall && !w_hs_bad;
    assign w_line_err   = w_in_lock && w_bl_fall && (r_xcnt != CORDW'(H_ACTIVE));
    assign w_pix        = w_in_lock && blank_n;

    assign w_x        = w_bl_rise ? '0 : r_xcnt;
    assign w_x_inc    = (w_x == {CORDW{1'b1}}) ? w_x : w_x + CORDW'(1);
    assign w_colr     = {vga_r[7 -: CHANW], vga_g[7 -: CHANW], vga_b[7 -: CHANW]};
    assign w_colr_ext = 16'(w_colr);
    assign w_unused_lsbs = ^{vga_r[7-CHANW:0], vga_g[7-CHANW:0], vga_b[7-CHANW:0]};

    assign locked = w_in_lock;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEARCH: if (w_hs_fall && w_period_ok) w_state_next = ALIGN;
            ALIGN: begin
                if (w_hs_bad)       w_state_next = SEARCH;
                else if (w_vs_fall) w_state_next = LOCKED;
            end
            LOCKED: if (w_hs_bad) w_state_next = SEARCH;
            default: w_state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= SEARCH;
            r_prev_hs  <= 1'b1;
            r_prev_vs  <= 1'b1;
            r_prev_bl  <= 1'b0;
            r_hcnt     <= '0;
            r_xcnt     <= '0;
            r_ycnt     <= '0;
            r_acc      <= '0;
            px         <= '0;
            py         <= '0;
            pix_valid  <= 1'b0;
            pix_colr   <= '0;
            frame_done <= 1'b0;
            checksum   <= '0;
            line_count <= '0;
            sync_err   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_prev_hs <= vga_hsync;
            r_prev_vs <= vga_vsync;
            r_prev_bl <= blank_n;

            if (w_hs_fall)               r_hcnt <= '0;
            else if (r_hcnt != 12'hFFF)  r_hcnt <= r_hcnt + 12'd1;

            if (w_pix) r_xcnt <= w_x_inc;

            if (w_enter_lock || w_frame_end)
                r_ycnt <= '0;
            else if (w_in_lock && w_bl_fall && (r_ycnt != {CORDW{1'b1}}))
                r_ycnt <= r_ycnt + CORDW'(1);

            // A pixel sampled together with the vsync fall opens the new frame's sum
            if (w_enter_lock)     r_acc <= '0;
            else if (w_frame_end) r_acc <= w_pix ? w_colr_ext : 16'd0;
            else if (w_pix)       r_acc <= r_acc + w_colr_ext;

            pix_valid <= w_pix;
            if (w_pix) begin
                px       <= w_x;
                py       <= r_ycnt;
                pix_colr <= w_colr;
            end

            frame_done <= w_frame_end;
            if (w_frame_end) begin
                checksum   <= r_acc;
                line_count <= r_ycnt;
            end

            sync_err <= (w_in_lock && w_hs_bad) || w_line_err ||
                        (w_frame_end && (r_ycnt != CORDW'(V_ACTIVE)));
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder on a reduced 48x30 raster
module tb_vga_sync_decoder;

    localparam int HT = 48, HA = 32, VA = 24, VT = 30;
    localparam int HS0 = 36, HS1 = 42, VS0 = 26, VS1 = 28;

    logic        clk = 1'b0, reset = 1'b0;
    logic        vga_hsync = 1'b1, vga_vsync = 1'b1, blank_n = 1'b0;
    logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic [15:0] px, py, checksum, line_count;
    logic        pix_valid, locked, frame_done, sync_err;
    logic [11:0] pix_colr;

    vga_sync_decoder #(.CORDW(16), .H_TOTAL(HT), .H_ACTIVE(HA), .V_ACTIVE(VA), .CHANW(4)) dut (
        .clk(clk), .reset(reset), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .blank_n(blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .px(px), .py(py), .pix_valid(pix_valid), .pix_colr(pix_colr), .locked(locked),
        .frame_done(frame_done), .checksum(checksum), .line_count(line_count),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0;
    int n_fd = 0, n_err = 0, n_both = 0, pix_bad = 0, n_valid = 0;
    logic [15:0] last_cs = '0, last_lc = '0;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    bit first_seen = 0;

    int n_lines = VA, short_line = -1, long_line = -1, rst_line = -1;
    bit grad = 0, chk_pix = 0;
    logic d_valid = 0, e_valid = 0;
    int d_x = 0, d_y = 0, e_x = 0, e_y = 0;
    logic [11:0] d_c = '0, e_c = '0;
    logic pre_locked, pre_valid;
    logic [79:0] snap;

    always @(posedge clk) begin
        e_valid <= d_valid; e_x <= d_x; e_y <= d_y; e_c <= d_c;
    end

    always @(negedge clk) begin
        if (frame_done) begin
            n_fd <= n_fd + 1; last_cs <= checksum; last_lc <= line_count;
        end
        if (sync_err) n_err <= n_err + 1;
        if (sync_err && frame_done) n_both <= n_both + 1;
        if (chk_pix) begin
            if (pix_valid !== e_valid ||
                (e_valid && (px !== 16'(e_x) || py !== 16'(e_y) || pix_colr !== e_c)))
                pix_bad <= pix_bad + 1;
            if (pix_valid) begin
                n_valid <= n_valid + 1; last_x <= int'(px); last_y <= int'(py);
                if (!first_seen) begin
                    first_seen <= 1; first_x <= int'(px); first_y <= int'(py);
                end
            end
        end
    end

    task automatic drive_line(input int ln);
        int nact, len;
        nact = (ln == long_line) ? HA + 1 : HA;
        len  = (ln == short_line) ? HT - 1 : HT;
        for (int h = 0; h < len; h++) begin
            @(negedge clk);
            vga_vsync = !(ln >= VS0 && ln < VS1);
            vga_hsync = !(h >= HS0 && h < HS1);
            blank_n   = (ln < n_lines) && (h < nact);
            if (grad) begin
                vga_r = {4'(h), 4'hA}; vga_g = {4'(h), 4'h5}; vga_b = {4'(h), 4'hF};
                d_c = {3{4'(h)}};
            end else begin
                vga_r = 8'h10; vga_g = 8'h30; vga_b = 8'h70;
                d_c = 12'h137;
            end
            d_valid = blank_n; d_x = h; d_y = ln;
            if (ln == rst_line && h == 10) begin
                pre_locked = locked; pre_valid = pix_valid;
                reset = 1'b0;
                #1;
                snap = {px, py, pix_valid, pix_colr, locked, frame_done, checksum, line_count, sync_err};
            end
            if (ln == rst_line && h == 13) reset = 1'b1;
        end
    endtask

    task automatic drive_lines(input int a, input int b);
        for (int l = a; l <= b; l++) drive_line(l);
        @(posedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if ({px, py, pix_valid, pix_colr} !== '0) begin n_bad++; $display("FAIL reset_pix: got %0h want 0", {px, py, pix_valid, pix_colr}); end
        n_vec++; if ({locked, frame_done, sync_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {locked, frame_done, sync_err}); end
        n_vec++; if ({checksum, line_count} !== 32'h0) begin n_bad++; $display("FAIL reset_sums: got %0h want 0", {checksum, line_count}); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock_solid;
        int f0, e0;
        f0 = n_fd; e0 = n_err;
        drive_lines(0, VS0 - 1);
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL prelock: got %b want 0", locked); end
        drive_lines(VS0, VT - 1);
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL lock: got %b want 1", locked); end
        n_vec++; if (n_fd - f0 !== 0) begin n_bad++; $display("FAIL first_vsync_fd: got %0d want 0", n_fd - f0); end
        drive_lines(0, VT - 1);
        n_vec++; if (n_fd - f0 !== 1) begin n_bad++; $display("FAIL solid_fd: got %0d want 1", n_fd - f0); end
        n_vec++; if (last_cs !== 16'hA500) begin n_bad++; $display("FAIL solid_cs: got %h want a500", last_cs); end
        n_vec++; if (last_lc !== 16'd24) begin n_bad++; $display("FAIL solid_lc: got %0d want 24", last_lc); end
        n_vec++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL solid_err: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_gradient;
        int f0, e0, b0, v0;
        f0 = n_fd; e0 = n_err; b0 = pix_bad; v0 = n_valid;
        grad = 1; chk_pix = 1;
        drive_lines(0, VT - 1);
        chk_pix = 0; grad = 0;
        n_vec++; if (pix_bad - b0 !== 0) begin n_bad++; $display("FAIL grad_pixels: got %0d bad want 0", pix_bad - b0); end
        n_vec++; if (n_valid - v0 !== HA * VA) begin n_bad++; $display("FAIL grad_count: got %0d want %0d", n_valid - v0, HA * VA); end
        n_vec++; if (first_x !== 0 || first_y !== 0) begin n_bad++; $display("FAIL grad_first: got %0d,%0d want 0,0", first_x, first_y); end
        n_vec++; if (last_x !== HA - 1 || last_y !== VA - 1) begin n_bad++; $display("FAIL grad_last: got %0d,%0d want 31,23", last_x, last_y); end
        n_vec++; if (n_fd - f0 !== 1 || last_cs !== 16'hFE80) begin n_bad++; $display("FAIL grad_cs: got %0d/%h want 1/fe80", n_fd - f0, last_cs); end
        n_vec++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL grad_err: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_short_line;
        int f0, e0;
        f0 = n_fd; e0 = n_err;
        short_line = 5;
        drive_lines(0, 6);
        n_vec++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL short_err: got %0d want 1", n_err - e0); end
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_unlock: got %b want 0", locked); end
        drive_lines(7, VS0 - 1);
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_align: got %b want 0", locked); end
        drive_lines(VS0, VT - 1);
        short_line = -1;
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL short_relock: got %b want 1", locked); end
        n_vec++; if (n_fd - f0 !== 0 || n_err - e0 !== 1) begin n_bad++; $display("FAIL short_fd_err: got %0d/%0d want 0/1", n_fd - f0, n_err - e0); end
    endtask

    task automatic test_short_frame;
        int f0, e0, b0;
        f0 = n_fd; e0 = n_err; b0 = n_both;
        n_lines = VA - 1;
        drive_lines(0, VT - 1);
        n_lines = VA;
        n_vec++; if (n_fd - f0 !== 1 || last_lc !== 16'd23) begin n_bad++; $display("FAIL sframe_lc: got %0d/%0d want 1/23", n_fd - f0, last_lc); end
        n_vec++; if (n_both - b0 !== 1 || n_err - e0 !== 1) begin n_bad++; $display("FAIL sframe_err: got %0d/%0d want 1/1", n_both - b0, n_err - e0); end
        n_vec++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sframe_lock: got %b want 1", locked); end
    endtask

    task automatic test_long_line;
        int f0, e0;
        f0 = n_fd; e0 = n_err;
        long_line = 10;
        drive_lines(0, 11);
        n_vec++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL long_err: got %0d want 1", n_err - e0); end
        drive_lines(12, VT - 1);
        long_line = -1;
        n_vec++; if (n_fd - f0 !== 1 || last_cs !== 16'hA637) begin n_bad++; $display("FAIL long_cs: got %0d/%h want 1/a637", n_fd - f0, last_cs); end
        n_vec++; if (last_lc !== 16'd24 || locked !== 1'b1 || n_err - e0 !== 1) begin n_bad++; $display("FAIL long_state: got %0d/%b/%0d want 24/1/1", last_lc, locked, n_err - e0); end
    endtask

    task automatic test_mid_reset;
        int f0, e0;
        f0 = n_fd; e0 = n_err;
        rst_line = 10;
        drive_lines(0, 10);
        rst_line = -1;
        n_vec++; if (pre_locked !== 1'b1 || pre_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_pre: got %b%b want 11", pre_locked, pre_valid); end
        n_vec++; if (snap !== '0) begin n_bad++; $display("FAIL mrst_zero: got %h want 0", snap); end
        drive_lines(11, VS0 - 1);
        n_vec++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mrst_unlocked: got %b want 0", locked); end
        drive_lines(VS0, VT - 1);
        n_vec++; if (locked !== 1'b1 || n_fd - f0 !== 0 || n_err - e0 !== 0) begin n_bad++; $display("FAIL mrst_relock: got %b/%0d/%0d want 1/0/0", locked, n_fd - f0, n_err - e0); end
        drive_lines(0, VT - 1);
        n_vec++; if (n_fd - f0 !== 1 || last_cs !== 16'hA500 || last_lc !== 16'd24) begin n_bad++; $display("FAIL mrst_cs: got %0d/%h/%0d want 1/a500/24", n_fd - f0, last_cs, last_lc); end
        n_vec++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL mrst_err: got %0d want 0", n_err - e0); end
    endtask

    initial begin
        test_reset;
        test_lock_solid;
        test_gradient;
        test_short_line;
        test_short_frame;
        test_long_line;
        test_mid_reset;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
